serial_cmd_frame_bridge: RTL and testbench

Parametrised framing bridge between a narrow external byte/word stream and the 64-bit command/in/out interface of main_core_serialCmd. It parses a header carrying the core command plus input and output word counts, issues the command, then packs EXT_W-bit beats into 64-bit words for the core and unpacks core 64-bit results into EXT_W-bit beats, both directions concurrently. This is the host-facing successor of the current single-width 64-bit stream interface.

---
 rtl/serial_cmd_frame_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_serial_cmd_frame_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_frame_bridge.sv
// serial_cmd_frame_bridge: parses a {out_len, in_len, cmd} header from a narrow
// EXT_W beat stream, hands the command to the core, then packs EXT_W beats into
// 64-bit core input words and unpacks 64-bit core results into EXT_W beats.
module serial_cmd_frame_bridge #(
    parameter int EXT_W     = 8,
    parameter int CMD_W     = 16,
    parameter int LEN_W     = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EXT_W-1:0] ext_in,
    input  logic             ext_in_isReady,
    output logic             ext_in_canReceive,
    output logic [EXT_W-1:0] ext_out,
    output logic             ext_out_isReady,
    input  logic             ext_out_canReceive,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_hasAny,
    input  logic             cmd_consume,
    output logic [63:0]      in,
    output logic             in_isReady,
    input  logic             in_canReceive,
    input  logic [63:0]      out,
    input  logic             out_isReady,
    output logic             out_canReceive,
    output logic             busy,
    output logic             frame_done
);

    localparam int BEATS    = 64 / EXT_W;
    localparam int HDR_BITS = CMD_W + 2 * LEN_W;
    localparam int HB       = (HDR_BITS + EXT_W - 1) / EXT_W;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HCNT_W   = (HB > 1) ? $clog2(HB) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [HCNT_W-1:0] LAST_HDR  = HCNT_W'(HB - 1);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_CMD, S_XFER} state_t;

    state_t                state_q, state_d;
    logic [HCNT_W-1:0]     hcnt_q, hcnt_d;
    logic [HB*EXT_W-1:0]   hdr_q, hdr_d, hdr_now;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic                  cmd_vld_q, cmd_vld_d;
    logic [LEN_W-1:0]      in_rem_q, in_rem_d;
    logic [LEN_W-1:0]      out_rem_q, out_rem_d;
    logic [CNT_W-1:0]      pk_cnt_q, pk_cnt_d;
    logic [63:0]           pk_data_q, pk_data_d;
    logic                  pk_full_q, pk_full_d;
    logic [CNT_W-1:0]      up_cnt_q, up_cnt_d;
    logic [63:0]           up_data_q, up_data_d;
    logic                  up_full_q, up_full_d;
    logic [EXT_W-1:0]      ext_out_q, ext_out_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  ext_in_fire, in_fire, out_fire, ext_out_fire;

    // Word slot (in EXT_W units) that beat k of a word occupies.
    function automatic int beat_pos(input logic [CNT_W-1:0] k);
        return MSB_FIRST ? (BEATS - 1 - int'(k)) : int'(k);
    endfunction

    function automatic logic [EXT_W-1:0] beat_sel(input logic [63:0] w, input logic [CNT_W-1:0] k);
        return w[beat_pos(k)*EXT_W +: EXT_W];
    endfunction

    // Ready signals decode the current state; held low while reset is asserted.
    always_comb begin
        ext_in_canReceive = rst && ((state_q == S_IDLE) || (state_q == S_HDR) ||
                            ((state_q == S_XFER) && (in_rem_q != '0) && !pk_full_q));
        out_canReceive    = rst && (state_q == S_XFER) && (out_rem_q != '0) && !up_full_q;
        ext_in_fire       = ext_in_isReady && ext_in_canReceive;
        in_fire           = pk_full_q && in_canReceive;
        out_fire          = out_isReady && out_canReceive;
        ext_out_fire      = up_full_q && ext_out_canReceive;
    end

    // Next-state logic: frame FSM, header capture, packer and unpacker.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        hdr_d        = hdr_q;
        cmd_d        = cmd_q;
        in_rem_d     = in_rem_q;
        out_rem_d    = out_rem_q;
        pk_cnt_d     = pk_cnt_q;
        pk_data_d    = pk_data_q;
        pk_full_d    = pk_full_q;
        up_cnt_d     = up_cnt_q;
        up_data_d    = up_data_q;
        up_full_d    = up_full_q;
        ext_out_d    = ext_out_q;
        frame_done_d = 1'b0;
        hdr_now      = hdr_q;
        hdr_now[int'(hcnt_q)*EXT_W +: EXT_W] = ext_in;

        case (state_q)
            S_IDLE, S_HDR: begin
                if (ext_in_fire) begin
                    hdr_d = hdr_now;
                    if (hcnt_q == LAST_HDR) begin
                        hcnt_d    = '0;
                        state_d   = S_CMD;
                        cmd_d     = hdr_now[CMD_W-1:0];
                        in_rem_d  = hdr_now[CMD_W +: LEN_W];
                        out_rem_d = hdr_now[CMD_W+LEN_W +: LEN_W];
                    end else begin
                        hcnt_d  = hcnt_q + HCNT_W'(1);
                        state_d = S_HDR;
                    end
                end
            end
            S_CMD: begin
                if (cmd_consume) begin
                    if ((in_rem_q == '0) && (out_rem_q == '0)) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if ((in_rem_q == '0) && (out_rem_q == '0) && !pk_full_q && !up_full_q) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Packer: only data beats (XFER) land here; header beats never do.
        if ((state_q == S_XFER) && ext_in_fire) begin
            pk_data_d[beat_pos(pk_cnt_q)*EXT_W +: EXT_W] = ext_in;
            if (pk_cnt_q == LAST_BEAT) begin
                pk_cnt_d  = '0;
                pk_full_d = 1'b1;
                in_rem_d  = in_rem_q - LEN_W'(1);
            end else begin
                pk_cnt_d = pk_cnt_q + CNT_W'(1);
            end
        end
        if (in_fire) pk_full_d = 1'b0;

        // Unpacker: capture and last-beat drain are exclusive via up_full_q.
        if (out_fire) begin
            up_data_d = out;
            up_full_d = 1'b1;
            up_cnt_d  = '0;
            ext_out_d = beat_sel(out, '0);
            out_rem_d = out_rem_q - LEN_W'(1);
        end
        if (ext_out_fire) begin
            if (up_cnt_q == LAST_BEAT) begin
                up_full_d = 1'b0;
                up_cnt_d  = '0;
            end else begin
                up_cnt_d  = up_cnt_q + CNT_W'(1);
                ext_out_d = beat_sel(up_data_q, up_cnt_q + CNT_W'(1));
            end
        end

        busy_d    = (state_d != S_IDLE);
        cmd_vld_d = (state_d == S_CMD);
    end

    // State and output registers; async reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hcnt_q       <= '0;
            hdr_q        <= '0;
            cmd_q        <= '0;
            cmd_vld_q    <= 1'b0;
            in_rem_q     <= '0;
            out_rem_q    <= '0;
            pk_cnt_q     <= '0;
            pk_data_q    <= '0;
            pk_full_q    <= 1'b0;
            up_cnt_q     <= '0;
            up_data_q    <= '0;
            up_full_q    <= 1'b0;
            ext_out_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            hdr_q        <= hdr_d;
            cmd_q        <= cmd_d;
            cmd_vld_q    <= cmd_vld_d;
            in_rem_q     <= in_rem_d;
            out_rem_q    <= out_rem_d;
            pk_cnt_q     <= pk_cnt_d;
            pk_data_q    <= pk_data_d;
            pk_full_q    <= pk_full_d;
            up_cnt_q     <= up_cnt_d;
            up_data_q    <= up_data_d;
            up_full_q    <= up_full_d;
            ext_out_q    <= ext_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cmd             = cmd_q;
    assign cmd_hasAny      = cmd_vld_q;
    assign in              = pk_data_q;
    assign in_isReady      = pk_full_q;
    assign ext_out         = ext_out_q;
    assign ext_out_isReady = up_full_q;
    assign busy            = busy_q;
    assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_serial_cmd_frame_bridge.sv
// Bench for serial_cmd_frame_bridge: an 8-bit LSB-first instance and a 32-bit
// MSB-first instance share one stimulus/observation port set selected by 'sel'.
module tb_serial_cmd_frame_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    bit          sel;
    logic [31:0] tb_ext_in;
    logic        tb_ext_in_vld, tb_ext_out_rdy, tb_cmd_consume, tb_in_rdy, tb_out_vld;
    logic [63:0] tb_out;

    logic        a_ext_in_rdy, a_ext_out_vld, a_cmd_vld, a_in_vld, a_out_rdy, a_busy, a_done;
    logic [7:0]  a_ext_out;
    logic [15:0] a_cmd;
    logic [63:0] a_in;
    logic        b_ext_in_rdy, b_ext_out_vld, b_cmd_vld, b_in_vld, b_out_rdy, b_busy, b_done;
    logic [31:0] b_ext_out;
    logic [15:0] b_cmd;
    logic [63:0] b_in;

    logic m_ext_in_rdy, m_ext_out_vld, m_cmd_vld, m_in_vld, m_out_rdy, m_busy, m_done;
    logic [31:0] m_ext_out;
    logic [15:0] m_cmd;
    logic [63:0] m_in;

    serial_cmd_frame_bridge #(.EXT_W(8), .CMD_W(16), .LEN_W(16), .MSB_FIRST(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .ext_in(tb_ext_in[7:0]), .ext_in_isReady(tb_ext_in_vld & ~sel), .ext_in_canReceive(a_ext_in_rdy),
        .ext_out(a_ext_out), .ext_out_isReady(a_ext_out_vld), .ext_out_canReceive(tb_ext_out_rdy & ~sel),
        .cmd(a_cmd), .cmd_hasAny(a_cmd_vld), .cmd_consume(tb_cmd_consume & ~sel),
        .in(a_in), .in_isReady(a_in_vld), .in_canReceive(tb_in_rdy & ~sel),
        .out(tb_out), .out_isReady(tb_out_vld & ~sel), .out_canReceive(a_out_rdy),
        .busy(a_busy), .frame_done(a_done));

    serial_cmd_frame_bridge #(.EXT_W(32), .CMD_W(16), .LEN_W(16), .MSB_FIRST(1'b1)) u_dut_b (
        .clk(clk), .rst(rst),
        .ext_in(tb_ext_in), .ext_in_isReady(tb_ext_in_vld & sel), .ext_in_canReceive(b_ext_in_rdy),
        .ext_out(b_ext_out), .ext_out_isReady(b_ext_out_vld), .ext_out_canReceive(tb_ext_out_rdy & sel),
        .cmd(b_cmd), .cmd_hasAny(b_cmd_vld), .cmd_consume(tb_cmd_consume & sel),
        .in(b_in), .in_isReady(b_in_vld), .in_canReceive(tb_in_rdy & sel),
        .out(tb_out), .out_isReady(tb_out_vld & sel), .out_canReceive(b_out_rdy),
        .busy(b_busy), .frame_done(b_done));

    assign m_ext_in_rdy  = sel ? b_ext_in_rdy  : a_ext_in_rdy;
    assign m_ext_out     = sel ? b_ext_out     : {24'b0, a_ext_out};
    assign m_ext_out_vld = sel ? b_ext_out_vld : a_ext_out_vld;
    assign m_cmd         = sel ? b_cmd         : a_cmd;
    assign m_cmd_vld     = sel ? b_cmd_vld     : a_cmd_vld;
    assign m_in          = sel ? b_in          : a_in;
    assign m_in_vld      = sel ? b_in_vld      : a_in_vld;
    assign m_out_rdy     = sel ? b_out_rdy     : a_out_rdy;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_done        = sel ? b_done        : a_done;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge clk) if (m_done) done_cnt <= done_cnt + 1;

    // Per-frame expectations prepared by the caller of run_frame.
    logic [31:0] f_din[$];
    logic [63:0] f_exp_in[$];
    logic [63:0] f_out_w[$];
    logic [31:0] f_exp_ob[$];

    typedef struct {
        bit          s;
        logic [15:0] cmd;
        int          nin;
        int          nout;
        logic [63:0] in_beats;   // beat k at bits [k*EXT_W +: EXT_W]
        logic [63:0] exp_in;
        logic [63:0] core_out;
        logic [63:0] exp_beats;  // expected ext_out beat k at bits [k*EXT_W +: EXT_W]
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference placement: beat k of a word sits at slot k, or slot BEATS-1-k when MSB-first.
    function automatic logic [31:0] beat_of(input logic [63:0] w, input int k, input int ew, input bit msb);
        int pos;
        logic [63:0] s;
        pos = msb ? (64 / ew - 1 - k) : k;
        s = w >> (pos * ew);
        return (ew == 32) ? s[31:0] : {24'b0, s[7:0]};
    endfunction

    // Offer one beat starting at a negedge; returns at the negedge after it was taken.
    task automatic send_beat(input logic [31:0] b, output bit ok);
        int t;
        bit acc;
        t = 0;
        tb_ext_in = b;
        tb_ext_in_vld = 1'b1;
        do begin
            acc = m_ext_in_rdy;
            @(negedge clk);
            t++;
        end while (!acc && t < 300);
        tb_ext_in_vld = 1'b0;
        ok = acc;
    endtask

    // One full frame with concurrent host sender, core, and host sink.
    task automatic run_frame(input logic [15:0] c, input int nin, input int nout, input bit echo, input int stall);
        int ew, bts, d0, n_in_taken, t;
        logic [47:0] hdr;
        logic [31:0] hb[$];
        ew = sel ? 32 : 8;
        bts = 64 / ew;
        d0 = done_cnt;
        n_in_taken = 0;
        hdr = {16'(nout), 16'(nin), c};
        if (ew == 8) begin
            for (int k = 0; k < 6; k++) hb.push_back({24'b0, hdr[k*8 +: 8]});
        end else begin
            hb.push_back(hdr[31:0]);
            hb.push_back({16'($urandom), hdr[47:32]});  // pad bits must be ignored
        end
        foreach (f_din[i]) hb.push_back(f_din[i]);
        fork
            begin : host_send
                bit ok;
                foreach (hb[i]) begin
                    repeat ($urandom_range(0, stall)) @(negedge clk);
                    send_beat(hb[i], ok);
                    if (!ok) begin chk("send_timeout", ok, 1); break; end
                end
            end
            begin : core_cmd
                int w;
                w = 0;
                while (!m_cmd_vld && w < 1000) begin @(negedge clk); w++; end
                chk("cmd_value", m_cmd, c);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                chk("cmd_still_valid", m_cmd_vld, 1);
                tb_cmd_consume = 1'b1;
                @(negedge clk);
                tb_cmd_consume = 1'b0;
            end
            begin : core_in
                for (int k = 0; k < nin; k++) begin
                    int w;
                    bit got;
                    w = 0;
                    got = 0;
                    while (!got && w < 1000) begin
                        tb_in_rdy = 1'($urandom_range(0, 1));
                        if (tb_in_rdy && m_in_vld) begin
                            chk("in_word", m_in, f_exp_in[k]);
                            got = 1;
                            n_in_taken++;
                        end
                        @(negedge clk);
                        w++;
                    end
                    tb_in_rdy = 1'b0;
                    if (!got) begin chk("in_timeout", got, 1); break; end
                end
            end
            begin : core_out
                for (int k = 0; k < nout; k++) begin
                    int w;
                    bit acc;
                    w = 0;
                    if (echo) begin
                        while (n_in_taken <= k && w < 1000) begin @(negedge clk); w++; end
                        @(negedge clk);
                    end
                    tb_out = f_out_w[k];
                    tb_out_vld = 1'b1;
                    do begin
                        acc = m_out_rdy;
                        @(negedge clk);
                        w++;
                    end while (!acc && w < 1000);
                    tb_out_vld = 1'b0;
                    if (!acc) begin chk("out_timeout", acc, 1); break; end
                end
            end
            begin : host_sink
                for (int j = 0; j < nout * bts; j++) begin
                    int w;
                    bit got;
                    w = 0;
                    got = 0;
                    while (!got && w < 1000) begin
                        tb_ext_out_rdy = 1'($urandom_range(0, 1));
                        if (tb_ext_out_rdy && m_ext_out_vld) begin
                            chk("ext_out_beat", m_ext_out, f_exp_ob[j]);
                            got = 1;
                        end
                        @(negedge clk);
                        w++;
                    end
                    tb_ext_out_rdy = 1'b0;
                    if (!got) begin chk("sink_timeout", got, 1); break; end
                end
            end
        join
        t = 0;
        while (m_busy && t < 50) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        chk("frame_idle", m_busy, 0);
        chk("frame_done_once", done_cnt - d0, 1);
    endtask

    task automatic clear_frame();
        f_din.delete();
        f_exp_in.delete();
        f_out_w.delete();
        f_exp_ob.delete();
    endtask

    // Random payloads with expectations derived from the beat placement rule.
    task automatic build_rand(input int nin, input int nout);
        int ew;
        logic [63:0] w;
        ew = sel ? 32 : 8;
        clear_frame();
        for (int i = 0; i < nin; i++) begin
            w = {$urandom, $urandom};
            f_exp_in.push_back(w);
            for (int k = 0; k < 64 / ew; k++) f_din.push_back(beat_of(w, k, ew, sel));
        end
        for (int i = 0; i < nout; i++) begin
            w = {$urandom, $urandom};
            f_out_w.push_back(w);
            for (int k = 0; k < 64 / ew; k++) f_exp_ob.push_back(beat_of(w, k, ew, sel));
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0]  exp_ob[8];
        logic [63:0] tmp;
        bit ok, all_ok, stable, seen;
        int idx, t, ew;

        vecs[0] = '{1'b0, 16'h1234, 1, 1, 64'h0807060504030201, 64'h0807060504030201,
                    64'hAABBCCDDEEFF0011, 64'hAABBCCDDEEFF0011};
        vecs[1] = '{1'b0, 16'h0005, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0};
        vecs[2] = '{1'b0, 16'hBEEF, 1, 0, 64'h8877665544332211, 64'h8877665544332211, 64'h0, 64'h0};
        vecs[3] = '{1'b0, 16'hC0DE, 0, 1, 64'h0, 64'h0, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
        vecs[4] = '{1'b1, 16'h4242, 1, 1, 64'h0506070801020304, 64'h0102030405060708,
                    64'hAABBCCDDEEFF0011, 64'hEEFF0011AABBCCDD};
        vecs[5] = '{1'b1, 16'h0005, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0};
        exp_ob = '{8'h11, 8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};

        rst = 1'b0; sel = 1'b0;
        tb_ext_in = '0; tb_ext_in_vld = 0; tb_ext_out_rdy = 0; tb_cmd_consume = 0;
        tb_in_rdy = 0; tb_out_vld = 0; tb_out = '0;
        all_ok = 1;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {m_ext_in_rdy, m_ext_out, m_ext_out_vld, m_cmd, m_cmd_vld,
                              m_in, m_in_vld, m_out_rdy, m_busy, m_done}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", m_busy, 0);
        chk("idle_ext_in_rdy", m_ext_in_rdy, 1);

        // Header 34 12 02 00 01 00: cmd 1234, in_len 2, out_len 1
        foreach (exp_ob[i]) ; // keep table visible; header beats follow
        send_beat(32'h34, ok); all_ok &= ok;
        send_beat(32'h12, ok); all_ok &= ok;
        send_beat(32'h02, ok); all_ok &= ok;
        send_beat(32'h00, ok); all_ok &= ok;
        send_beat(32'h01, ok); all_ok &= ok;
        send_beat(32'h00, ok); all_ok &= ok;
        chk("hdr_cmd_valid", m_cmd_vld, 1);
        chk("hdr_cmd_value", m_cmd, 16'h1234);
        chk("cmd_blocks_ext_in", m_ext_in_rdy, 0);
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            if (!(m_cmd_vld && m_cmd == 16'h1234 && !m_ext_in_rdy)) stable = 0;
        end
        chk("cmd_held_stalled", stable, 1);
        tb_cmd_consume = 1'b1;
        @(negedge clk);
        tb_cmd_consume = 1'b0;
        chk("cmd_dropped", m_cmd_vld, 0);
        chk("busy_xfer", m_busy, 1);

        // Pack order and in-side backpressure
        for (int k = 1; k <= 8; k++) begin send_beat(32'(k), ok); all_ok &= ok; end
        chk("pack_word0", m_in, 64'h0807060504030201);
        chk("pack_word0_vld", m_in_vld, 1);
        stable = 1;
        repeat (3) begin
            @(negedge clk);
            if (!(m_in_vld && m_in == 64'h0807060504030201 && !m_ext_in_rdy)) stable = 0;
        end
        chk("in_held_stalled", stable, 1);
        tb_in_rdy = 1'b1;
        @(negedge clk);
        tb_in_rdy = 1'b0;
        chk("in_taken", m_in_vld, 0);
        chk("ext_in_reopen", m_ext_in_rdy, 1);
        for (int k = 1; k <= 8; k++) begin send_beat(32'(8'h10 + k), ok); all_ok &= ok; end
        chk("pack_word1", m_in, 64'h1817161514131211);
        tb_in_rdy = 1'b1;
        @(negedge clk);
        tb_in_rdy = 1'b0;
        chk("ext_in_closed_in_rem0", m_ext_in_rdy, 0);
        chk("directed_sends", all_ok, 1);

        // Unpack with toggling host ready
        tb_out = 64'hAABBCCDDEEFF0011;
        tb_out_vld = 1'b1;
        chk("out_rdy_open", m_out_rdy, 1);
        @(negedge clk);
        tb_out_vld = 1'b0;
        chk("out_rdy_closed", m_out_rdy, 0);
        idx = 0; t = 0; stable = 1;
        while (idx < 8 && t < 40) begin
            tb_ext_out_rdy = t[0];
            if (!m_ext_out_vld || m_ext_out[7:0] != exp_ob[idx] || m_out_rdy) stable = 0;
            if (tb_ext_out_rdy && m_ext_out_vld) begin
                chk("unpack_beat", m_ext_out, {24'b0, exp_ob[idx]});
                idx++;
            end
            @(negedge clk);
            t++;
        end
        tb_ext_out_rdy = 1'b0;
        chk("unpack_stable", stable, 1);
        chk("unpack_count", idx, 8);
        chk("unpack_drained", m_ext_out_vld, 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (m_done) begin seen = 1; break; end
        end
        chk("frame_done_seen", seen, 1);
        @(negedge clk);
        chk("frame_done_pulse", m_done, 0);
        chk("idle_after_frame", m_busy, 0);

        // Reset mid-XFER with a half-full packer
        all_ok = 1;
        send_beat(32'hAA, ok); all_ok &= ok;
        send_beat(32'h00, ok); all_ok &= ok;
        send_beat(32'h02, ok); all_ok &= ok;
        for (int k = 0; k < 3; k++) begin send_beat(32'h00, ok); all_ok &= ok; end
        tb_cmd_consume = 1'b1;
        @(negedge clk);
        tb_cmd_consume = 1'b0;
        for (int k = 0; k < 4; k++) begin send_beat(32'hC0 + 32'(k), ok); all_ok &= ok; end
        chk("pre_reset_sends", all_ok, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_outputs", {m_ext_in_rdy, m_ext_out, m_ext_out_vld, m_cmd, m_cmd_vld,
                                    m_in, m_in_vld, m_out_rdy, m_busy, m_done}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", m_busy, 0);
        chk("post_reset_ext_in_rdy", m_ext_in_rdy, 1);
        chk("post_reset_in_vld", m_in_vld, 0);

        // Table-driven frames
        foreach (vecs[i]) begin
            sel = vecs[i].s;
            ew = sel ? 32 : 8;
            clear_frame();
            if (vecs[i].nin > 0) begin
                for (int k = 0; k < 64 / ew; k++) begin
                    tmp = vecs[i].in_beats >> (k * ew);
                    f_din.push_back(ew == 32 ? tmp[31:0] : {24'b0, tmp[7:0]});
                end
                f_exp_in.push_back(vecs[i].exp_in);
            end
            if (vecs[i].nout > 0) begin
                f_out_w.push_back(vecs[i].core_out);
                for (int k = 0; k < 64 / ew; k++) begin
                    tmp = vecs[i].exp_beats >> (k * ew);
                    f_exp_ob.push_back(ew == 32 ? tmp[31:0] : {24'b0, tmp[7:0]});
                end
            end
            run_frame(vecs[i].cmd, vecs[i].nin, vecs[i].nout, 1'b0, 2);
        end

        // Concurrency on the 32-bit instance: core echoes a result after each input word
        sel = 1'b1;
        build_rand(3, 3);
        run_frame(16'h0C0C, 3, 3, 1'b1, 0);

        // Randomized frames against the reference model
        for (int r = 0; r < 16; r++) begin
            int ni, no;
            sel = r[0];
            ni = $urandom_range(0, 3);
            no = $urandom_range(0, 3);
            build_rand(ni, no);
            run_frame(16'($urandom), ni, no, 1'b0, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
